// File: rtl/multi_adder_pkg.sv
// Shared sizing helpers and operand conditioning for the multi-channel adder
// and its output FIFO.
package multi_adder_pkg;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int out_width(input int width, input int n, input int acc);
        return width + clog2(n * acc);
    endfunction

    function automatic int level_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // Operands wider than 64 bits are outside what this helper supports.
    function automatic logic [63:0] ext_neg(input logic [63:0] value, input int width,
                                            input logic sign_ext, input logic negate);
        logic [63:0] upper_mask;
        logic [63:0] low_bits;
        logic [63:0] result;
        logic        msb;
        upper_mask = ~64'd0 << width;
        low_bits   = value & ~upper_mask;
        msb        = |(value & (64'd1 << (width - 1)));
        result     = (sign_ext && msb) ? (low_bits | upper_mask) : low_bits;
        if (negate) begin
            result = -result;
        end
        return result;
    endfunction

endpackage

// File: rtl/hs_fifo.sv
// Valid/ready FIFO with registered head entry; accepts a push while full
// only when the head is leaving in the same cycle.
module hs_fifo
    import multi_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [WIDTH-1:0]              in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [WIDTH-1:0]              out_data_o,
    output logic [level_width(DEPTH)-1:0] level_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic             push;
    logic             pop;

    always_comb begin
        out_valid_o = (level_q != '0);
        in_ready_o  = (level_q != FULL_LVL) || out_ready_i;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        out_data_o  = mem_q[rptr_q];
        level_o     = level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= in_data_i;
                wptr_q        <= (wptr_q == LAST_SLOT) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == LAST_SLOT) ? '0 : rptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_adder.sv
// Joins N valid/ready channels, adds or subtracts each operand, optionally
// accumulates ACC joined beats, and queues results in an output FIFO.
module multi_adder
    import multi_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N      = 2,
    parameter int ACC    = 1,
    parameter int DEPTH  = 2,
    parameter int SIGNED = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N-1:0]                        in_valid,
    output logic [N-1:0]                        in_ready,
    input  logic [N*WIDTH-1:0]                  in_data,
    input  logic [N-1:0]                        in_sub,
    output logic                                S_valid,
    input  logic                                S_ready,
    output logic [out_width(WIDTH, N, ACC)-1:0] S_data,
    output logic [level_width(DEPTH)-1:0]       level
);

    localparam int OW = out_width(WIDTH, N, ACC);
    localparam int CW = (ACC > 1) ? clog2(ACC) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(ACC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] beat_sum;
    logic [OW-1:0] acc_next;
    logic [63:0]   operand;
    logic          all_valid;
    logic          final_beat;
    logic          fifo_ready;
    logic          fire;
    logic          push;

    // Truncating each conditioned operand to OW keeps the sum exact modulo 2^OW.
    always_comb begin
        beat_sum = '0;
        operand  = '0;
        for (int i = 0; i < N; i++) begin
            operand  = ext_neg(64'(in_data[i*WIDTH +: WIDTH]), WIDTH, SIGNED != 0, in_sub[i]);
            beat_sum = beat_sum + OW'(operand);
        end
    end

    always_comb begin
        all_valid  = &in_valid;
        final_beat = (cnt_q == LAST_BEAT);
        fire       = all_valid && (!final_beat || fifo_ready);
        push       = fire && final_beat;
        in_ready   = {N{fire}};
        acc_next   = ((cnt_q == '0) ? '0 : acc_q) + beat_sum;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        if (fire) begin
            acc_d = acc_next;
            cnt_d = final_beat ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    hs_fifo #(
        .WIDTH(OW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (push),
        .in_ready_o  (fifo_ready),
        .in_data_i   (acc_next),
        .out_valid_o (S_valid),
        .out_ready_i (S_ready),
        .out_data_o  (S_data),
        .level_o     (level)
    );

endmodule

// File: tb/tb_multi_adder.sv
// Scoreboard bench for multi_adder across four configurations: plain 2-way
// unsigned, 3-way signed, 4-beat accumulation and a single-channel stream.
module tb_multi_adder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int expQ[$];

    // A: N=2, ACC=1, unsigned, OW=9
    logic [1:0]  aValid, aReady, aSub;
    logic [15:0] aData;
    logic        aSValid, aSReady;
    logic [8:0]  aSData;
    logic [1:0]  aLevel;
    // B: N=3, ACC=1, signed, OW=10
    logic [2:0]  bValid, bReady, bSub;
    logic [23:0] bData;
    logic        bSValid, bSReady;
    logic [9:0]  bSData;
    logic [1:0]  bLevel;
    // C: N=2, ACC=4, unsigned, OW=11
    logic [1:0]  cValid, cReady, cSub;
    logic [15:0] cData;
    logic        cSValid, cSReady;
    logic [10:0] cSData;
    logic [1:0]  cLevel;
    // D: N=1, ACC=1, unsigned, OW=8
    logic [0:0]  dValid, dReady, dSub;
    logic [7:0]  dData;
    logic        dSValid, dSReady;
    logic [7:0]  dSData;
    logic [1:0]  dLevel;

    multi_adder #(.WIDTH(8), .N(2), .ACC(1), .DEPTH(2), .SIGNED(0)) dutA (
        .clk(clk), .reset(reset), .in_valid(aValid), .in_ready(aReady), .in_data(aData),
        .in_sub(aSub), .S_valid(aSValid), .S_ready(aSReady), .S_data(aSData), .level(aLevel));
    multi_adder #(.WIDTH(8), .N(3), .ACC(1), .DEPTH(2), .SIGNED(1)) dutB (
        .clk(clk), .reset(reset), .in_valid(bValid), .in_ready(bReady), .in_data(bData),
        .in_sub(bSub), .S_valid(bSValid), .S_ready(bSReady), .S_data(bSData), .level(bLevel));
    multi_adder #(.WIDTH(8), .N(2), .ACC(4), .DEPTH(2), .SIGNED(0)) dutC (
        .clk(clk), .reset(reset), .in_valid(cValid), .in_ready(cReady), .in_data(cData),
        .in_sub(cSub), .S_valid(cSValid), .S_ready(cSReady), .S_data(cSData), .level(cLevel));
    multi_adder #(.WIDTH(8), .N(1), .ACC(1), .DEPTH(2), .SIGNED(0)) dutD (
        .clk(clk), .reset(reset), .in_valid(dValid), .in_ready(dReady), .in_data(dData),
        .in_sub(dSub), .S_valid(dSValid), .S_ready(dSReady), .S_data(dSData), .level(dLevel));

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_signed3(logic [23:0] d, logic [2:0] sub);
        int s = 0;
        for (int i = 0; i < 3; i++) begin
            int v;
            v = $signed(d[i*8 +: 8]);
            s = s + (sub[i] ? -v : v);
        end
        return s & 1023;
    endfunction

    function automatic int model_unsigned2(logic [15:0] d, logic [1:0] sub);
        int a = int'(d[7:0]);
        int b = int'(d[15:8]);
        return ((sub[0] ? -a : a) + (sub[1] ? -b : b)) & 511;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        #1;
        checks++; if (aSValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_valid got=%b want=0", aSValid); end
        checks++; if (aSData !== 9'd0) begin errors++; $display("[TB] FAIL reset_a_data got=%0d want=0", aSData); end
        checks++; if (aLevel !== 2'd0) begin errors++; $display("[TB] FAIL reset_a_level got=%0d want=0", aLevel); end
        checks++; if (aReady !== 2'b00) begin errors++; $display("[TB] FAIL reset_a_ready got=%b want=00", aReady); end
        checks++; if (cSValid !== 1'b0 || cLevel !== 2'd0) begin errors++; $display("[TB] FAIL reset_c_state got valid=%b level=%0d want 0/0", cSValid, cLevel); end
        checks++; if (bSData !== 10'd0) begin errors++; $display("[TB] FAIL reset_b_data got=%0d want=0", bSData); end
        reset = 1'b0;
    endtask

    task automatic test_join();
        int exp;
        step();
        aSReady = 1'b1; aSub = 2'b00; aData = {8'd100, 8'd200}; aValid = 2'b01;
        #1;
        checks++; if (aReady !== 2'b00) begin errors++; $display("[TB] FAIL join_partial_ready got=%b want=00", aReady); end
        step();
        aValid = 2'b11;
        #1;
        checks++; if (aReady !== 2'b11) begin errors++; $display("[TB] FAIL join_full_ready got=%b want=11", aReady); end
        checks++; if (aSValid !== 1'b0) begin errors++; $display("[TB] FAIL join_early_valid got=%b want=0", aSValid); end
        expQ.push_back(200 + 100);
        step();
        aValid = 2'b00;
        #1;
        checks++;
        if (aSValid !== 1'b1 || expQ.size() == 0) begin
            errors++; $display("[TB] FAIL join_latency got valid=%b want=1", aSValid);
        end else begin
            exp = expQ.pop_front();
            if (aSData !== 9'(exp)) begin errors++; $display("[TB] FAIL join_sum got=%0d want=%0d", aSData, exp); end
        end
        step();
        #1;
        checks++; if (aSValid !== 1'b0 || aLevel !== 2'd0) begin errors++; $display("[TB] FAIL join_drain got valid=%b level=%0d want 0/0", aSValid, aLevel); end
    endtask

    task automatic test_signed();
        int exp;
        expQ.delete();
        step();
        bSReady = 1'b1; bSub = 3'b010; bData = {8'hFD, 8'd20, 8'd5}; bValid = 3'b111;
        #1;
        checks++; if (bReady !== 3'b111) begin errors++; $display("[TB] FAIL signed_ready got=%b want=111", bReady); end
        expQ.push_back(model_signed3(bData, bSub));
        step();
        bSub = 3'b101; bData = {8'd1, 8'd127, 8'h80};
        #1;
        checks++;
        if (bSValid !== 1'b1 || expQ.size() == 0) begin
            errors++; $display("[TB] FAIL signed_first_valid got=%b want=1", bSValid);
        end else begin
            exp = expQ.pop_front();
            if (bSData !== 10'(exp)) begin errors++; $display("[TB] FAIL signed_first got=%h want=%h", bSData, 10'(exp)); end
        end
        expQ.push_back(model_signed3(bData, bSub));
        step();
        bValid = 3'b000;
        #1;
        checks++;
        if (bSValid !== 1'b1 || expQ.size() == 0) begin
            errors++; $display("[TB] FAIL signed_second_valid got=%b want=1", bSValid);
        end else begin
            exp = expQ.pop_front();
            if (bSData !== 10'(exp)) begin errors++; $display("[TB] FAIL signed_second got=%h want=%h", bSData, 10'(exp)); end
        end
    endtask

    task automatic test_accumulate();
        int sum = 0;
        step();
        cSReady = 1'b1; cSub = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            cValid = 2'b11;
            cData  = {8'(2*k + 2), 8'(2*k + 1)};
            sum    = sum + (2*k + 1) + (2*k + 2);
            #1;
            checks++; if (cReady !== 2'b11) begin errors++; $display("[TB] FAIL acc_ready beat=%0d got=%b want=11", k, cReady); end
            checks++; if (cSValid !== 1'b0) begin errors++; $display("[TB] FAIL acc_early_valid beat=%0d got=%b want=0", k, cSValid); end
        end
        step();
        cValid = 2'b00;
        #1;
        checks++; if (cSValid !== 1'b1 || cSData !== 11'(sum)) begin errors++; $display("[TB] FAIL acc_result got valid=%b data=%0d want 1/%0d", cSValid, cSData, sum); end
        step();
        #1;
        checks++; if (cSValid !== 1'b0) begin errors++; $display("[TB] FAIL acc_single got valid=%b want=0", cSValid); end
    endtask

    task automatic test_backpressure();
        int exp;
        expQ.delete();
        step();
        aSReady = 1'b0; aSub = 2'b00; aValid = 2'b11; aData = {8'd1, 8'd10};
        #1;
        checks++; if (aReady !== 2'b11) begin errors++; $display("[TB] FAIL bp_first_ready got=%b want=11", aReady); end
        expQ.push_back(model_unsigned2(aData, aSub));
        step();
        aData = {8'd2, 8'd20};
        #1;
        checks++; if (aReady !== 2'b11) begin errors++; $display("[TB] FAIL bp_second_ready got=%b want=11", aReady); end
        expQ.push_back(model_unsigned2(aData, aSub));
        step();
        aData = {8'd3, 8'd30};
        #1;
        checks++; if (aLevel !== 2'd2) begin errors++; $display("[TB] FAIL bp_full_level got=%0d want=2", aLevel); end
        checks++; if (aReady !== 2'b00) begin errors++; $display("[TB] FAIL bp_full_ready got=%b want=00", aReady); end
        step();
        aSReady = 1'b1;
        #1;
        checks++; if (aReady !== 2'b11) begin errors++; $display("[TB] FAIL bp_pushpop_ready got=%b want=11", aReady); end
        checks++;
        if (expQ.size() == 0) begin
            errors++; $display("[TB] FAIL bp_head got=%0d want=<none>", aSData);
        end else begin
            exp = expQ.pop_front();
            if (aSData !== 9'(exp)) begin errors++; $display("[TB] FAIL bp_head got=%0d want=%0d", aSData, exp); end
        end
        expQ.push_back(model_unsigned2(aData, aSub));
        for (int k = 0; k < 4; k++) begin
            step();
            aValid = 2'b00;
            #1;
            if (k == 0) begin
                checks++; if (aLevel !== 2'd2) begin errors++; $display("[TB] FAIL bp_level_hold got=%0d want=2", aLevel); end
            end
            if (aSValid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL bp_order got=%0d want=<none>", aSData);
                end else begin
                    exp = expQ.pop_front();
                    if (aSData !== 9'(exp)) begin errors++; $display("[TB] FAIL bp_order got=%0d want=%0d", aSData, exp); end
                end
            end
        end
        checks++; if (expQ.size() != 0 || aLevel !== 2'd0) begin errors++; $display("[TB] FAIL bp_drain got pending=%0d level=%0d want 0/0", expQ.size(), aLevel); end
    endtask

    task automatic test_back_to_back();
        int exp;
        expQ.delete();
        aSReady = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            aValid = 2'b11;
            aData  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            aSub   = 2'($urandom_range(0, 3));
            #1;
            checks++; if (aReady !== 2'b11) begin errors++; $display("[TB] FAIL b2b_ready beat=%0d got=%b want=11", k, aReady); end
            if (k > 0) begin
                checks++;
                if (aSValid !== 1'b1 || expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL b2b_valid beat=%0d got=%b want=1", k, aSValid);
                end else begin
                    exp = expQ.pop_front();
                    if (aSData !== 9'(exp)) begin errors++; $display("[TB] FAIL b2b_data beat=%0d got=%0d want=%0d", k, aSData, exp); end
                end
            end
            expQ.push_back(model_unsigned2(aData, aSub));
        end
        step();
        aValid = 2'b00;
        #1;
        checks++;
        if (aSValid !== 1'b1 || expQ.size() == 0) begin
            errors++; $display("[TB] FAIL b2b_last got valid=%b want=1", aSValid);
        end else begin
            exp = expQ.pop_front();
            if (aSData !== 9'(exp)) begin errors++; $display("[TB] FAIL b2b_last got=%0d want=%0d", aSData, exp); end
        end
    endtask

    task automatic test_reset_mid();
        step();
        cSReady = 1'b0; cSub = 2'b00; cValid = 2'b11; cData = {8'd1, 8'd1};
        repeat (3) step();
        step();
        cData = {8'd2, 8'd2};
        step();
        step();
        cValid = 2'b00;
        #1;
        checks++; if (cLevel !== 2'd1) begin errors++; $display("[TB] FAIL rst_mid_pre_level got=%0d want=1", cLevel); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (cLevel !== 2'd0 || cSValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_clear got level=%0d valid=%b want 0/0", cLevel, cSValid); end
        cSReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            cValid = 2'b11; cData = {8'd1, 8'd1};
            #1;
            checks++; if (cSValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_residue beat=%0d got valid=%b want=0", k, cSValid); end
        end
        step();
        cValid = 2'b00;
        #1;
        checks++; if (cSValid !== 1'b1 || cSData !== 11'(4 * (1 + 1))) begin errors++; $display("[TB] FAIL rst_mid_result got valid=%b data=%0d want 1/8", cSValid, cSData); end
    endtask

    task automatic test_random_stream();
        int  sent = 0;
        int  recv = 0;
        int  cyc = 0;
        int  exp;
        bit  firedPrev = 1'b0;
        expQ.delete();
        dSub = 1'b0;
        dValid = 1'b0;
        while (((sent < 1000) || (recv < sent)) && (cyc < 20000)) begin
            step();
            cyc++;
            if (firedPrev) dValid = 1'b0;
            if (!dValid[0] && (sent < 1000) && ($urandom_range(0, 3) != 0)) begin
                dValid = 1'b1;
                dData  = 8'($urandom_range(0, 255));
            end
            dSReady = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (dLevel > 2'd2) begin errors++; $display("[TB] FAIL stream_level got=%0d want<=2", dLevel); end
            if (dSValid && dSReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL stream_dup got=%0d want=<none>", dSData);
                end else begin
                    exp = expQ.pop_front();
                    if (dSData !== 8'(exp)) begin errors++; $display("[TB] FAIL stream_data idx=%0d got=%0d want=%0d", recv, dSData, exp); end
                end
                recv++;
            end
            firedPrev = dValid[0] && dReady[0];
            if (firedPrev) begin
                expQ.push_back(int'(dData));
                sent++;
            end
        end
        dValid = 1'b0;
        dSReady = 1'b0;
        checks++; if (recv != 1000 || expQ.size() != 0) begin errors++; $display("[TB] FAIL stream_count got recv=%0d pending=%0d want 1000/0", recv, expQ.size()); end
    endtask

    initial begin
        reset = 1'b1;
        aValid = '0; aSub = '0; aData = '0; aSReady = 1'b0;
        bValid = '0; bSub = '0; bData = '0; bSReady = 1'b0;
        cValid = '0; cSub = '0; cData = '0; cSReady = 1'b0;
        dValid = '0; dSub = '0; dData = '0; dSReady = 1'b0;
        test_reset();
        test_join();
        test_signed();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
